fpu_i2f_wb_stage: RTL and testbench
===================================

FPU_I2F_WB_STAGE -- requirements
Module: fpu_i2f_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning result buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discard all buffered results.
REQ-005 SHALL have port in_valid  input  1  conversion result present.
REQ-006 SHALL have port in_ready  output  1  buffer can accept.
REQ-007 SHALL have port in_rec_data  input  65  recoded result from the int-to-FP/FMV stage; single results in [32:0] with upper bits zero.
REQ-008 SHALL have port in_exc  input  5  exception flags {NV,DZ,OF,UF,NX}.
REQ-009 SHALL have port in_fp64  input  1  1 = double result, 0 = single.
REQ-010 SHALL have port in_rd  input  5  FP destination register.
REQ-011 SHALL have port out_valid  output  1  head entry valid.
REQ-012 SHALL have port out_ready  input  1  FP register file write port accepts.
REQ-013 SHALL have port out_data  output  64  IEEE-754 write data, NaN-boxed when single.
REQ-014 SHALL have port out_rd  output  5  destination register of head entry.
REQ-015 SHALL have port out_exc  output  5  flags of head entry.
REQ-016 SHALL have port fflags  output  5  sticky accumulated flags.
REQ-017 SHALL have port fflags_clr  input  1  clear sticky flags (CSR write).

Function
REQ-018 SHALL convert in_rec_data to IEEE combinationally at the input: fp64 via 11/53 recFN-to-FN, single via 8/24 recFN-to-FN; the converted value, not the recoded form, is stored.
REQ-019 SHALL form single out_data as {32'hFFFF_FFFF, f32}; double out_data as f64.
REQ-020 SHALL push when in_valid & in_ready; pop when out_valid & out_ready; FIFO order preserved.
REQ-021 SHALL drive in_ready = (count < DEPTH), independent of out_ready (no combinational ready path).
REQ-022 SHALL have latency of one cycle: an entry pushed in cycle N raises out_valid in cycle N+1 at the earliest; no input-to-output bypass.
REQ-023 SHALL on simultaneous push and pop leave count unchanged; when full, push is refused even if a pop occurs in the same cycle.
REQ-024 SHALL hold out_data/out_rd/out_exc stable while out_valid & !out_ready.
REQ-025 SHALL update fflags_next = (fflags_clr ? 0 : fflags) | (pop ? out_exc : 0); a flag popped in the clear cycle survives.
REQ-026 SHALL on flush empty the buffer next cycle (count=0, pointers=0), ignore any same-cycle push or pop, and leave fflags untouched.
REQ-027 SHALL wrap read/write pointers modulo DEPTH; count width is clog2(DEPTH)+1.
REQ-028 SHALL drive out_data/out_rd/out_exc to zero when out_valid is 0.

Reset
REQ-029 SHALL on rst set count, pointers, fflags to 0, giving out_valid=0, in_ready=1, out_data=0, out_rd=0, out_exc=0.
REQ-030 SHALL let rst take priority over flush, push, pop and fflags_clr; rst mid-transfer discards all entries.

Structure
REQ-031 SHALL place the flag-bit index constants (NV=4..NX=0), the NaN-box constant and the result-entry struct {data64, rd5, exc5} in the shared FPU package.
REQ-032 SHALL instance the existing HardFloat recFN-to-FN converters; the storage is one sub-module, fpu_res_fifo, parameterised by DEPTH and entry type.

Verification
REQ-033 SHALL cover: single push in_rec_data=65'h0_8000_0000, fp64=0, rd=3 -> next cycle out_valid=1, out_data=64'hFFFF_FFFF_3F80_0000, out_rd=3.
REQ-034 SHALL cover: push in_rec_data=65'h0_8000_0000_0000_0000, fp64=1, in_exc=5'h01 -> out_data=64'h3FF0_0000_0000_0000; after pop fflags=5'h01.
REQ-035 SHALL cover: out_ready=0, three back-to-back pushes with DEPTH=2 -> in_ready=0 after second, third held; release out_ready -> results drain in order with no loss or duplication.
REQ-036 SHALL cover: fflags=5'h01, pop with out_exc=5'h10 in same cycle as fflags_clr -> fflags=5'h10.
REQ-037 SHALL cover: two entries buffered, flush asserted with in_valid=1 -> next cycle out_valid=0, in_ready=1, fflags unchanged.
REQ-038 SHALL cover: rst asserted while full and out_ready=1 -> next cycle all outputs zero, in_ready=1, fflags=0.

Source files
------------

// File: rtl/fpu_i2f_wb_stage_pkg.sv
// Shared FPU definitions: exception flag positions, NaN-box constant and the
// write-back result entry carried through the int-to-FP result buffer.
package fpu_i2f_wb_stage_pkg;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [31:0] NANBOX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [4:0]  exc;
    } res_entry_t;

    function automatic logic [63:0] nan_box32(input logic [31:0] f);
        return {NANBOX, f};
    endfunction

endpackage

// File: rtl/fpu_i2f_wb_stage_fifo.sv
// Result buffer for the FP write-back path: DEPTH-entry circular FIFO with
// synchronous reset and flush; pointers wrap naturally at power-of-two depth.
module fpu_res_fifo
    import fpu_i2f_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = res_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t wdata_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   full_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fpu_i2f_wb_stage_recfn.sv
// HardFloat-compatible recoded-to-IEEE converter (recFNToFN), parameterised
// by exponent and significand width.
module recFNToFN #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic [expWidth+sigWidth:0]   in,
    output logic [expWidth+sigWidth-1:0] out
);
    localparam int SHW = $clog2(sigWidth - 1);
    localparam logic [expWidth:0]   MIN_NORM_EXP = (expWidth+1)'((1 << (expWidth - 1)) + 2);
    localparam logic [expWidth-1:0] EXP_BIAS     = expWidth'((1 << (expWidth - 1)) + 1);

    logic                  sign;
    logic [expWidth:0]     sExp;
    logic [sigWidth-2:0]   fract;
    logic                  isZero;
    logic                  isSpecial;
    logic                  isNaN;
    logic                  isInf;
    logic                  isSubnormal;
    logic [SHW-1:0]        denormShiftDist;
    logic [sigWidth-1:0]   denormSig;
    logic [expWidth-1:0]   expOut;
    logic [sigWidth-2:0]   fractOut;

    assign sign  = in[expWidth+sigWidth];
    assign sExp  = in[expWidth+sigWidth-1 -: expWidth+1];
    assign fract = in[sigWidth-2:0];

    assign isZero      = (sExp[expWidth -: 3] == 3'b000);
    assign isSpecial   = (sExp[expWidth -: 2] == 2'b11);
    assign isNaN       = isSpecial &  sExp[expWidth-2];
    assign isInf       = isSpecial & ~sExp[expWidth-2];
    assign isSubnormal = (sExp < MIN_NORM_EXP);

    // Subnormals re-insert the hidden bit and shift right by the distance the
    // recoded exponent sits below the minimum normal exponent.
    assign denormShiftDist = SHW'(1) - sExp[SHW-1:0];
    assign denormSig       = {1'b0, ~isZero, fract[sigWidth-2:1]} >> denormShiftDist;

    always_comb begin
        expOut   = isSubnormal ? '0 : (sExp[expWidth-1:0] - EXP_BIAS);
        expOut   = expOut | {expWidth{isNaN | isInf}};
        fractOut = isSubnormal ? denormSig[sigWidth-2:0] : (isInf ? '0 : fract);
    end

    assign out = {sign, expOut, fractOut};

endmodule

// File: rtl/fpu_i2f_wb_stage.sv
// Int-to-FP / FMV write-back stage: converts recoded results to IEEE at the
// input, buffers them for the FP register file and accumulates sticky fflags.
module fpu_i2f_wb_stage
    import fpu_i2f_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:0] in_rec_data,
    input  logic [4:0]  in_exc,
    input  logic        in_fp64,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_exc,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);
    logic [31:0] f32;
    logic [63:0] f64;
    res_entry_t  in_entry;
    res_entry_t  head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [4:0]  fflags_q, fflags_d;

    recFNToFN #(.expWidth(8), .sigWidth(24)) u_cvt32 (
        .in  (in_rec_data[32:0]),
        .out (f32)
    );

    recFNToFN #(.expWidth(11), .sigWidth(53)) u_cvt64 (
        .in  (in_rec_data),
        .out (f64)
    );

    always_comb begin
        in_entry.data = in_fp64 ? f64 : nan_box32(f32);
        in_entry.rd   = in_rd;
        in_entry.exc  = in_exc;
    end

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid  & in_ready  & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    fpu_res_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (res_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_entry),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign out_data = out_valid ? head.data : '0;
    assign out_rd   = out_valid ? head.rd   : '0;
    assign out_exc  = out_valid ? head.exc  : '0;

    // Clear is applied before OR-ing, so a flag popped in the clear cycle survives.
    always_comb begin
        fflags_d = (fflags_clr ? '0 : fflags_q) | (pop ? out_exc : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;

endmodule

// File: tb/tb_fpu_i2f_wb_stage.sv
// Directed bench for fpu_i2f_wb_stage: conversion vector table plus
// backpressure, sticky-flag, flush and reset sequences.
module tb_fpu_i2f_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] in_rec_data;
    logic [4:0]  in_exc;
    logic        in_fp64;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [4:0]  out_exc;
    logic [4:0]  fflags;
    logic        fflags_clr;

    fpu_i2f_wb_stage #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rec_data (in_rec_data),
        .in_exc      (in_exc),
        .in_fp64     (in_fp64),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_exc     (out_exc),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] rec;
        logic        fp64;
        logic [4:0]  exc;
        logic [4:0]  rd;
        logic [63:0] exp_data;
    } vec_t;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive(input logic [64:0] rec, input logic fp64, input logic [4:0] exc,
                         input logic [4:0] rd);
        in_valid    = 1'b1;
        in_rec_data = rec;
        in_fp64     = fp64;
        in_exc      = exc;
        in_rd       = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [13];
        logic [4:0]  exp_ff;
        logic [4:0]  got_rd [$];
        logic [63:0] got_data [$];
        logic        c_acc;

        vecs[0]  = '{65'h0_8000_0000,           1'b0, 5'h00, 5'd3,  64'hFFFF_FFFF_3F80_0000};
        vecs[1]  = '{65'h0_8000_0000_0000_0000, 1'b1, 5'h01, 5'd4,  64'h3FF0_0000_0000_0000};
        vecs[2]  = '{65'h0_0000_0000,           1'b0, 5'h00, 5'd5,  64'hFFFF_FFFF_0000_0000};
        vecs[3]  = '{65'h1_8080_0000,           1'b0, 5'h02, 5'd6,  64'hFFFF_FFFF_C000_0000};
        vecs[4]  = '{65'h0_C000_0000,           1'b0, 5'h04, 5'd7,  64'hFFFF_FFFF_7F80_0000};
        vecs[5]  = '{65'h0_E040_0000,           1'b0, 5'h10, 5'd8,  64'hFFFF_FFFF_7FC0_0000};
        vecs[6]  = '{65'h0_4100_0000,           1'b0, 5'h00, 5'd9,  64'hFFFF_FFFF_0080_0000};
        vecs[7]  = '{65'h0_4080_0000,           1'b0, 5'h03, 5'd10, 64'hFFFF_FFFF_0040_0000};
        vecs[8]  = '{65'h0_3580_0000,           1'b0, 5'h03, 5'd11, 64'hFFFF_FFFF_0000_0001};
        vecs[9]  = '{65'h1_0000_0000_0000_0000, 1'b1, 5'h00, 5'd12, 64'h8000_0000_0000_0000};
        vecs[10] = '{65'h0_8018_0000_0000_0000, 1'b1, 5'h00, 5'd13, 64'h4008_0000_0000_0000};
        vecs[11] = '{65'h0_C000_0000_0000_0000, 1'b1, 5'h04, 5'd14, 64'h7FF0_0000_0000_0000};
        vecs[12] = '{65'h0_4010_0000_0000_0000, 1'b1, 5'h01, 5'd31, 64'h0008_0000_0000_0000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rec_data = '0; in_exc = '0;
        in_fp64 = 1'b0; in_rd = '0; out_ready = 1'b0; fflags_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_out_rd",    64'(out_rd),    64'd0);
        check("rst_out_exc",   64'(out_exc),   64'd0);
        check("rst_fflags",    64'(fflags),    64'd0);
        rst = 1'b0;

        // Conversion table: push, observe one cycle later, pop, accumulate flags
        exp_ff = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].rec, vecs[i].fp64, vecs[i].exc, vecs[i].rd);
            check($sformatf("v%0d_no_bypass", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_data", i),  out_data,       vecs[i].exp_data);
            check($sformatf("v%0d_rd", i),    64'(out_rd),    64'(vecs[i].rd));
            check($sformatf("v%0d_exc", i),   64'(out_exc),   64'(vecs[i].exc));
            exp_ff |= vecs[i].exc;
            @(negedge clk);
            check($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
            check($sformatf("v%0d_fflags", i),  64'(fflags),    64'(exp_ff));
        end

        // Backpressure: three pushes into a 2-deep buffer, then drain
        out_ready = 1'b0;
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        check("clr_fflags", 64'(fflags), 64'd0);
        drive(65'h0_8000_0000, 1'b0, 5'h00, 5'd7);
        @(negedge clk);
        drive(65'h0_8000_0000_0000_0000, 1'b1, 5'h00, 5'd8);
        @(negedge clk);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_head_rd", 64'(out_rd), 64'd7);
        drive(65'h1_8080_0000, 1'b0, 5'h00, 5'd9);
        @(negedge clk);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_rd",   64'(out_rd), 64'd7);
        check("bp_hold_data", out_data, 64'hFFFF_FFFF_3F80_0000);
        out_ready = 1'b1;
        c_acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (c_acc) in_valid = 1'b0;
            if (out_valid) begin
                got_rd.push_back(out_rd);
                got_data.push_back(out_data);
            end
            if (in_valid && in_ready) c_acc = 1'b1;
            @(negedge clk);
        end
        check("bp_drain_count", 64'(got_rd.size()), 64'd3);
        if (got_rd.size() == 3) begin
            check("bp_order0", 64'(got_rd[0]), 64'd7);
            check("bp_order1", 64'(got_rd[1]), 64'd8);
            check("bp_order2", 64'(got_rd[2]), 64'd9);
            check("bp_data1",  got_data[1], 64'h3FF0_0000_0000_0000);
            check("bp_data2",  got_data[2], 64'hFFFF_FFFF_C000_0000);
        end
        in_valid = 1'b0;

        // Sticky flags: pop in the same cycle as the clear keeps the popped flag
        drive(65'h0_8000_0000, 1'b0, 5'h01, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("ff_set_nx", 64'(fflags), 64'h01);
        out_ready = 1'b0;
        drive(65'h0_8000_0000, 1'b0, 5'h10, 5'd2);
        @(negedge clk);
        in_valid = 1'b0;
        check("ff_no_pop", 64'(fflags), 64'h01);
        check("ff_head_exc", 64'(out_exc), 64'h10);
        out_ready = 1'b1;
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        check("ff_clr_pop", 64'(fflags), 64'h10);
        check("ff_empty", 64'(out_valid), 64'd0);

        // Flush with two entries buffered and a push presented
        out_ready = 1'b0;
        drive(65'h0_8000_0000, 1'b0, 5'h01, 5'd3);
        @(negedge clk);
        drive(65'h0_8000_0000, 1'b0, 5'h02, 5'd4);
        @(negedge clk);
        drive(65'h0_8000_0000, 1'b0, 5'h04, 5'd5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        check("fl_fflags",    64'(fflags),    64'h10);
        check("fl_out_data",  out_data,       64'd0);

        // Flush with room left: the same-cycle push and pop are both dropped
        out_ready = 1'b1;
        drive(65'h0_8000_0000, 1'b0, 5'h08, 5'd6);
        @(negedge clk);
        drive(65'h0_8000_0000, 1'b0, 5'h08, 5'd7);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl2_out_valid", 64'(out_valid), 64'd0);
        check("fl2_fflags",    64'(fflags),    64'h10);
        @(negedge clk);
        check("fl2_still_empty", 64'(out_valid), 64'd0);

        // Reset while full with out_ready high
        out_ready = 1'b0;
        drive(65'h0_8000_0000, 1'b0, 5'h04, 5'd8);
        @(negedge clk);
        drive(65'h0_8000_0000, 1'b0, 5'h04, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        check("rs_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_in_ready",  64'(in_ready),  64'd1);
        check("rs_out_data",  out_data,       64'd0);
        check("rs_out_rd",    64'(out_rd),    64'd0);
        check("rs_out_exc",   64'(out_exc),   64'd0);
        check("rs_fflags",    64'(fflags),    64'd0);
        @(negedge clk);
        check("rs_discarded", 64'(out_valid), 64'd0);
        check("rs_fflags2",   64'(fflags),    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
